// File: rtl/char_pkg.sv
// Shared definitions for the per-character sprite controllers and the colour mapper:
// motion states, the walk status codes, and the screen geometry.
package char_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_L = 2'd1,
    WALK_R = 2'd2
  } state_t;

  localparam logic [3:0] STATUS_IDLE   = 4'b0000;
  localparam logic [3:0] STATUS_WALK_L = 4'b0001;
  localparam logic [3:0] STATUS_WALK_R = 4'b0010;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  function automatic logic [3:0] status_of(input state_t s);
    case (s)
      WALK_L:  status_of = STATUS_WALK_L;
      WALK_R:  status_of = STATUS_WALK_R;
      default: status_of = STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous vertical sync into the Clk domain and emits a
// one-cycle pulse on each rising edge of the synchronised signal.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs,
  output logic frame_tick
);

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;

  // Reset clears the edge register too, so a half-seen edge cannot fire later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;

endmodule

// File: rtl/character_sprite_ctrl.sv
// Motion/animation controller for one character: frame-ticked walk FSM,
// clamped horizontal position, and the pixel hit test / sprite ROM address.
module character_sprite_ctrl
  import char_pkg::*;
#(
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 32,
  parameter int unsigned START_X    = 40,
  parameter int unsigned START_Y    = 400,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 608,
  parameter int unsigned STEP       = 2,
  parameter int unsigned IDLE_DELAY = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       block_left,
  input  logic       block_right,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [3:0] status,
  output logic       is_char,
  output logic [9:0] char_address
);

  localparam int unsigned CNT_W = $clog2(IDLE_DELAY + 1);

  logic             frame_tick;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [9:0]       pos_x_q, pos_x_d;
  logic [3:0]       status_q;

  frame_tick_gen u_frame_tick (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vs         (vs),
    .frame_tick (frame_tick)
  );

  logic       go_left, go_right;
  logic [10:0] pos_ext, right_ext;
  logic [9:0]  left_pos, right_pos;

  assign go_left  = key_left & ~key_right;
  assign go_right = key_right & ~key_left;

  // 11-bit arithmetic keeps a left step near zero from wrapping to ~1022.
  assign pos_ext   = {1'b0, pos_x_q};
  assign right_ext = pos_ext + 11'(STEP);
  assign left_pos  = (pos_ext < 11'(X_MIN + STEP)) ? 10'(X_MIN) : 10'(pos_ext - 11'(STEP));
  assign right_pos = (right_ext > 11'(X_MAX)) ? 10'(X_MAX) : right_ext[9:0];

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    pos_x_d    = pos_x_q;
    if (frame_tick) begin
      if (go_left) begin
        state_d    = WALK_L;
        idle_cnt_d = '0;
        if (!block_left) pos_x_d = left_pos;
      end else if (go_right) begin
        state_d    = WALK_R;
        idle_cnt_d = '0;
        if (!block_right) pos_x_d = right_pos;
      end else if (state_q != IDLE) begin
        if (idle_cnt_q == CNT_W'(IDLE_DELAY - 1)) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      pos_x_q    <= 10'(START_X);
      status_q   <= STATUS_IDLE;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      pos_x_q    <= pos_x_d;
      status_q   <= status_of(state_d);
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = 10'(START_Y);
  assign status = status_q;

  // Combinational so the mapper's ROM lookup stays aligned with DrawX/DrawY.
  logic [10:0] dx_off, dy_off;
  logic        in_x, in_y;

  assign dx_off  = {1'b0, DrawX} - {1'b0, pos_x};
  assign dy_off  = {1'b0, DrawY} - {1'b0, pos_y};
  assign in_x    = (DrawX >= pos_x) && (dx_off < 11'(SPRITE_W));
  assign in_y    = (DrawY >= pos_y) && (dy_off < 11'(SPRITE_H));
  assign is_char = in_x & in_y;

  assign char_address = is_char ? 10'((dy_off * 11'(SPRITE_W)) + dx_off) : 10'd0;

endmodule

// File: tb/tb_character_sprite_ctrl.sv
// Bench for character_sprite_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized keys and pixels.
module tb_character_sprite_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n, vs, key_left, key_right, block_left, block_right;
  logic [9:0] DrawX, DrawY;
  logic [9:0] pos_x, pos_y, char_address;
  logic [3:0] status;
  logic       is_char;
  logic [9:0] pos_x2, pos_y2, char_address2;
  logic [3:0] status2;
  logic       is_char2;

  character_sprite_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs),
    .key_left(key_left), .key_right(key_right),
    .block_left(block_left), .block_right(block_right),
    .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .status(status),
    .is_char(is_char), .char_address(char_address)
  );

  // Odd start position so the right clamp from 607 is exercised.
  character_sprite_ctrl #(.START_X(607)) dut_edge (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs),
    .key_left(1'b0), .key_right(1'b1),
    .block_left(block_left), .block_right(1'b0),
    .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x2), .pos_y(pos_y2), .status(status2),
    .is_char(is_char2), .char_address(char_address2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: vs sampled at each Clk edge; a rising edge seen in the
  // samples takes effect three edges after vs went high.
  logic [2:0] m_hist;
  int m_pos, m_dir, m_quiet;

  function automatic void model_step(input int p, input int d, input int q,
                                     input logic kl, input logic kr,
                                     input logic bl, input logic br,
                                     output int np, output int nd, output int nq);
    np = p; nd = d; nq = q;
    if (kl && !kr) begin
      nd = 1; nq = 0;
      if (!bl) np = (p - 2 < 0) ? 0 : p - 2;
    end else if (kr && !kl) begin
      nd = 2; nq = 0;
      if (!br) np = (p + 2 > 608) ? 608 : p + 2;
    end else if (d != 0) begin
      nq = q + 1;
      if (nq == 4) begin nd = 0; nq = 0; end
    end
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    int np, nd, nq;
    if (!Reset_n) begin
      m_hist  <= 3'b000;
      m_pos   <= 40;
      m_dir   <= 0;
      m_quiet <= 0;
    end else begin
      m_hist <= {m_hist[1:0], vs};
      if (m_hist[1] && !m_hist[2]) begin
        model_step(m_pos, m_dir, m_quiet, key_left, key_right, block_left, block_right, np, nd, nq);
        m_pos   <= np;
        m_dir   <= nd;
        m_quiet <= nq;
      end
    end
  end

  initial begin
    forever begin
      int dx, dy, exp_in, exp_addr;
      @(negedge Clk);
      #2;
      dx = int'(DrawX);
      dy = int'(DrawY);
      exp_in   = (dx >= m_pos && dx < m_pos + 32 && dy >= 400 && dy < 432) ? 1 : 0;
      exp_addr = exp_in ? (((dy - 400) * 32 + (dx - m_pos)) % 1024) : 0;
      chk("model_pos_x", int'(pos_x), m_pos);
      chk("model_pos_y", int'(pos_y), 400);
      chk("model_status", int'(status), m_dir);
      chk("model_is_char", int'(is_char), exp_in);
      chk("model_char_address", int'(char_address), exp_addr);
    end
  end

  task automatic frame(input int n);
    repeat (n) begin
      @(negedge Clk); vs = 1'b1;
      repeat (4) @(negedge Clk);
      vs = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      vs = (i >= 1 && i < 5);
      if ($urandom_range(0, 2) == 0) begin
        key_left    = 1'($urandom_range(0, 1));
        key_right   = 1'($urandom_range(0, 1));
        block_left  = ($urandom_range(0, 4) == 0);
        block_right = ($urandom_range(0, 4) == 0);
      end
      DrawX = 10'(m_pos - 4 + int'($urandom_range(0, 40)));
      DrawY = 10'(396 + int'($urandom_range(0, 40)));
    end
  endtask

  task automatic hit(input int x, input int y, input int exp_in, input int exp_addr, input string name);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
    chk({name, "_is_char"}, int'(is_char), exp_in);
    chk({name, "_addr"}, int'(char_address), exp_addr);
  endtask

  initial begin
    Reset_n = 1'b0; vs = 1'b0;
    key_left = 1'b0; key_right = 1'b0; block_left = 1'b0; block_right = 1'b0;
    DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    key_right = 1'b1;
    vs = 1'b1; repeat (5) @(negedge Clk);
    vs = 1'b0; repeat (3) @(negedge Clk);
    #1;
    chk("reset_pos_x", int'(pos_x), 40);
    chk("reset_pos_y", int'(pos_y), 400);
    chk("reset_status", int'(status), 0);
    key_right = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;

    frame(1); #1;
    chk("nokey_pos_x", int'(pos_x), 40);
    chk("nokey_status", int'(status), 0);
    chk("edge_clamp_607", int'(pos_x2), 608);

    hit(40, 400, 1, 0, "hit_topleft");
    hit(71, 431, 1, 1023, "hit_botright");
    hit(72, 431, 0, 0, "hit_right_out");
    hit(39, 400, 0, 0, "hit_left_out");

    key_right = 1'b1;
    frame(3); #1;
    chk("walk_r_pos_x", int'(pos_x), 46);
    chk("walk_r_status", int'(status), 2);
    key_right = 1'b0;
    frame(3); #1;
    chk("idle_wait_status", int'(status), 2);
    frame(1); #1;
    chk("idle_back_status", int'(status), 0);
    chk("idle_back_pos_x", int'(pos_x), 46);

    key_right = 1'b1;
    frame(1);
    key_left = 1'b1;
    frame(4); #1;
    chk("both_keys_pos_x", int'(pos_x), 48);
    chk("both_keys_status", int'(status), 0);

    key_left = 1'b0; block_right = 1'b1;
    frame(1); #1;
    chk("block_r_pos_x", int'(pos_x), 48);
    chk("block_r_status", int'(status), 2);
    block_right = 1'b0; key_right = 1'b0;

    key_left = 1'b1;
    frame(26); #1;
    chk("left_clamp_pos_x", int'(pos_x), 0);
    chk("left_clamp_status", int'(status), 1);
    key_left = 1'b0;

    key_right = 1'b1;
    frame(310); #1;
    chk("right_clamp_pos_x", int'(pos_x), 608);
    chk("right_clamp_status", int'(status), 2);
    chk("edge_still_608", int'(pos_x2), 608);

    repeat (300) random_frame();

    key_left = 1'b0; key_right = 1'b1; block_left = 1'b0; block_right = 1'b0;
    repeat (8) @(negedge Clk);
    vs = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b0; vs = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    #1;
    chk("stale_edge_pos_x", int'(pos_x), 40);
    chk("stale_edge_status", int'(status), 0);
    frame(1); #1;
    chk("post_reset_tick_pos_x", int'(pos_x), 42);
    chk("post_reset_tick_status", int'(status), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
